// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_unit
// Purpose  : MIPS CP0 exception/interrupt unit at the MEM/WB boundary.
//            Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13)
//            and EPC(14). Prioritises exceptions and interrupts, commits them,
//            handles ERET, drives pipeline flush and PC redirect, and services
//            MTC0 writes and MFC0 reads.
// Option   : define CP0_TIMER_EN to build the Count/Compare timer. Without it,
//            Count and Compare read 0, ignore writes, and Cause.TI stays 0.
// Ports    : clk, resetn (async active-low)
//            instr_valid, exc_vec[31:0], pc, is_ds, bad_addr - MEM-stage info
//            hw_int[5:0]                  - level-sensitive interrupt lines
//            we, waddr, wdata             - MTC0 write port
//            raddr -> rdata               - MFC0 read port (combinational)
//            flush, redirect_pc, epc_out  - pipeline control outputs
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  input  logic [31:0] exc_vec,
  input  logic [31:0] pc,
  input  logic        is_ds,
  input  logic [31:0] bad_addr,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out
);

  // CP0 register numbers
  localparam logic [4:0] C_REG_BADVADDR = 5'd8;
  localparam logic [4:0] C_REG_COUNT    = 5'd9;
  localparam logic [4:0] C_REG_COMPARE  = 5'd11;
  localparam logic [4:0] C_REG_STATUS   = 5'd12;
  localparam logic [4:0] C_REG_CAUSE    = 5'd13;
  localparam logic [4:0] C_REG_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] C_EXC_INT  = 5'h00;
  localparam logic [4:0] C_EXC_ADEL = 5'h04;
  localparam logic [4:0] C_EXC_ADES = 5'h05;
  localparam logic [4:0] C_EXC_SYS  = 5'h08;
  localparam logic [4:0] C_EXC_BP   = 5'h09;
  localparam logic [4:0] C_EXC_RI   = 5'h0a;
  localparam logic [4:0] C_EXC_OV   = 5'h0c;

  // Status / Cause bit positions
  localparam int C_ST_IE  = 0;
  localparam int C_ST_EXL = 1;
  localparam int C_CA_TI  = 30;
  localparam int C_CA_BD  = 31;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        int_req;
  logic        any_exc;
  logic        exc_taken;
  logic        eret_fire;
  logic        mtc0_fire;
  logic        rd_bypass;
  logic [4:0]  exc_code;
  logic        bad_load;
  logic [31:0] bad_src;
  logic        ti_d;

  // exc_vec[31:8] carry no meaning for this unit
  logic unused_exc_hi;
  assign unused_exc_hi = ^exc_vec[31:8];

  // --------------------------------------------------------------------------
  // Event qualification. Exceptions beat ERET, and either one drops a
  // same-cycle MTC0 so a committed exception never races a software write.
  // resetn is folded in so flush stays low while reset is held.
  // --------------------------------------------------------------------------
  assign int_req   = status_q[C_ST_IE] & ~status_q[C_ST_EXL] &
                     (|(cause_q[15:8] & status_q[15:8]));
  assign any_exc   = |exc_vec[6:0];
  assign exc_taken = resetn & instr_valid & (int_req | any_exc);
  assign eret_fire = resetn & instr_valid & exc_vec[7] & ~exc_taken;
  assign mtc0_fire = we & ~exc_taken & ~eret_fire;
  assign rd_bypass = mtc0_fire & (raddr == waddr);

  // --------------------------------------------------------------------------
  // Priority encoder. Note the order is not bit order: Ov (bit3) outranks
  // Sys (bit2). Only the winning cause may load BadVAddr.
  // --------------------------------------------------------------------------
  always_comb begin
    exc_code = C_EXC_INT;
    bad_load = 1'b0;
    bad_src  = pc;
    if (int_req) begin
      exc_code = C_EXC_INT;
    end else if (exc_vec[0]) begin
      exc_code = C_EXC_ADEL;
      bad_load = 1'b1;
      bad_src  = pc;
    end else if (exc_vec[1]) begin
      exc_code = C_EXC_RI;
    end else if (exc_vec[3]) begin
      exc_code = C_EXC_OV;
    end else if (exc_vec[2]) begin
      exc_code = C_EXC_SYS;
    end else if (exc_vec[4]) begin
      exc_code = C_EXC_BP;
    end else if (exc_vec[5]) begin
      exc_code = C_EXC_ADEL;
      bad_load = 1'b1;
      bad_src  = bad_addr;
    end else if (exc_vec[6]) begin
      exc_code = C_EXC_ADES;
      bad_load = 1'b1;
      bad_src  = bad_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Optional Count/Compare timer
  // --------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] count_inc;
  logic        count_wr;
  logic        compare_wr;
  logic        ti_hit;

  assign count_inc  = count_q + 32'd1;
  assign count_wr   = mtc0_fire & (waddr == C_REG_COUNT);
  assign compare_wr = mtc0_fire & (waddr == C_REG_COMPARE);

  // Match is judged on the incremented value; a software Count write
  // replaces the increment and so cannot raise TI in the same cycle.
  assign ti_hit = tick_q & ~count_wr & (count_inc == compare_q);
  assign ti_d   = compare_wr ? 1'b0 : (cause_q[C_CA_TI] | ti_hit);

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    if (tick_q) begin
      count_d = count_inc;
    end
    if (count_wr) begin
      count_d = wdata;
    end
    if (compare_wr) begin
      compare_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end
`else
  assign ti_d = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state for Status, Cause, EPC, BadVAddr
  // --------------------------------------------------------------------------
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    // Hardware pending bits are resampled every cycle; IP7 shares the
    // timer interrupt with hw_int[5].
    cause_d[15:10]  = {hw_int[5] | cause_q[C_CA_TI], hw_int[4:0]};
    cause_d[C_CA_TI] = ti_d;

    if (exc_taken) begin
      // A nested exception (EXL already set) keeps the original return point.
      if (!status_q[C_ST_EXL]) begin
        epc_d            = is_ds ? (pc - 32'd4) : pc;
        cause_d[C_CA_BD] = is_ds;
      end
      status_d[C_ST_EXL] = 1'b1;
      cause_d[6:2]       = exc_code;
      if (bad_load) begin
        badvaddr_d = bad_src;
      end
    end else if (eret_fire) begin
      status_d[C_ST_EXL] = 1'b0;
    end else if (mtc0_fire) begin
      case (waddr)
        C_REG_STATUS: begin
          status_d[15:8] = wdata[15:8];
          status_d[1:0]  = wdata[1:0];
        end
        C_REG_CAUSE: begin
          cause_d[9:8] = wdata[9:8];
        end
        C_REG_EPC: begin
          epc_d = wdata;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // --------------------------------------------------------------------------
  // MFC0 read port; a same-cycle MTC0 to the same register returns the value
  // the register will hold after the edge.
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (raddr)
      C_REG_BADVADDR: rdata = rd_bypass ? badvaddr_d : badvaddr_q;
`ifdef CP0_TIMER_EN
      C_REG_COUNT:    rdata = rd_bypass ? count_d : count_q;
      C_REG_COMPARE:  rdata = rd_bypass ? compare_d : compare_q;
`endif
      C_REG_STATUS:   rdata = rd_bypass ? status_d : status_q;
      C_REG_CAUSE:    rdata = rd_bypass ? cause_d : cause_q;
      C_REG_EPC:      rdata = rd_bypass ? epc_d : epc_q;
      default:        rdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline control
  // --------------------------------------------------------------------------
  assign flush       = exc_taken | eret_fire;
  assign redirect_pc = exc_taken ? EXC_VECTOR :
                       (eret_fire ? epc_q : 32'h0000_0000);
  assign epc_out     = (mtc0_fire && (waddr == C_REG_EPC)) ? wdata : epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_unit
// Purpose  : Self-checking bench for cp0_exc_unit. Directed scenario tasks
//            plus a randomized run, all compared against a field-level model
//            of the CP0 architectural state.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cp0_exc_unit;

  logic        clk;
  logic        resetn;
  logic        instr_valid;
  logic [31:0] exc_vec;
  logic [31:0] pc;
  logic        is_ds;
  logic [31:0] bad_addr;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] epc_out;

  int n_vec;
  int n_err;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  cp0_exc_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr_valid (instr_valid),
    .exc_vec     (exc_vec),
    .pc          (pc),
    .is_ds       (is_ds),
    .bad_addr    (bad_addr),
    .hw_int      (hw_int),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: architectural fields kept separately
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        ie;
    logic        exl;
    logic [7:0]  im;
    logic        bd;
    logic        ti;
    logic [7:0]  ip;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;
  } mstate_t;

  mstate_t ms;

  // Exception bits in decreasing priority (interrupt is handled first)
  localparam int ORDER [7] = '{0, 1, 3, 2, 4, 5, 6};

  function automatic logic [4:0] code_of(int b);
    case (b)
      0: return 5'h04;
      1: return 5'h0a;
      2: return 5'h08;
      3: return 5'h0c;
      4: return 5'h09;
      5: return 5'h04;
      6: return 5'h05;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic m_int_req(mstate_t s);
    return s.ie && !s.exl && ((s.ip & s.im) != 8'h00);
  endfunction

  function automatic logic m_exc(mstate_t s);
    return instr_valid && (m_int_req(s) || (exc_vec[6:0] != 7'h00));
  endfunction

  function automatic logic m_eret(mstate_t s);
    return instr_valid && exc_vec[7] && !m_exc(s);
  endfunction

  function automatic logic m_mtc0(mstate_t s);
    return we && !m_exc(s) && !m_eret(s);
  endfunction

  // Winning source: -1 interrupt, 0..6 exception bit, 8 nothing
  function automatic int m_winner(mstate_t s);
    if (m_int_req(s)) return -1;
    for (int i = 0; i < 7; i++) begin
      if (exc_vec[ORDER[i]]) return ORDER[i];
    end
    return 8;
  endfunction

  function automatic logic [31:0] m_read(mstate_t s, logic [4:0] a);
    case (a)
      5'd8:  return s.bad;
      5'd9:  return s.count;
      5'd11: return s.compare;
      5'd12: return 32'h0040_0000 | ({24'h0, s.im} << 8) | {30'h0, s.exl, s.ie};
      5'd13: return {s.bd, s.ti, 14'h0, s.ip, 1'b0, s.code, 2'b00};
      5'd14: return s.epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic mstate_t m_next(mstate_t s);
    mstate_t n;
    int      w;
    n = s;
    n.ip[7:2] = {hw_int[5] | s.ti, hw_int[4:0]};
`ifdef CP0_TIMER_EN
    n.tick = ~s.tick;
    if (s.tick) n.count = s.count + 32'd1;
    if (s.tick && (s.count + 32'd1 == s.compare) && !(m_mtc0(s) && waddr == 5'd9))
      n.ti = 1'b1;
    if (m_mtc0(s) && waddr == 5'd11) n.ti = 1'b0;
`endif
    if (m_exc(s)) begin
      w = m_winner(s);
      if (!s.exl) begin
        n.epc = is_ds ? pc - 32'd4 : pc;
        n.bd  = is_ds;
      end
      n.exl  = 1'b1;
      n.code = (w < 0) ? 5'h00 : code_of(w);
      if (w == 0) n.bad = pc;
      else if (w == 5 || w == 6) n.bad = bad_addr;
    end else if (m_eret(s)) begin
      n.exl = 1'b0;
    end else if (m_mtc0(s)) begin
      case (waddr)
        5'd12: begin n.im = wdata[15:8]; n.exl = wdata[1]; n.ie = wdata[0]; end
        5'd13: n.ip[1:0] = wdata[9:8];
        5'd14: n.epc = wdata;
`ifdef CP0_TIMER_EN
        5'd9:  n.count = wdata;
        5'd11: n.compare = wdata;
`endif
        default: ;
      endcase
    end
    return n;
  endfunction

  // Advance one clock: model consumes the inputs present before the edge
  task automatic tick();
    mstate_t nx;
    nx = m_next(ms);
    @(posedge clk);
    ms = nx;
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; exc_vec = '0; is_ds = 1'b0; we = 1'b0;
    waddr = '0; wdata = '0; pc = '0; bad_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    hw_int = '0;
    resetn = 1'b0;
    ms     = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    mtc0(5'd12, 32'h0000_0002);
    mtc0(5'd9, 32'h0000_0055);
    raddr = 5'd12; #1;
    n_vec++;
    if (rdata !== 32'h0040_0002) begin
      n_err++; $display("FAIL pre_reset_status: actual=%h required=%h", rdata, 32'h0040_0002);
    end
    #3;
    resetn = 1'b0; ms = '0; #1;
    n_vec++;
    if (rdata !== 32'h0040_0000) begin
      n_err++; $display("FAIL reset_status: actual=%h required=%h", rdata, 32'h0040_0000);
    end
    raddr = 5'd13; #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_cause: actual=%h required=0", rdata);
    end
    raddr = 5'd14; #1;
    n_vec++;
    if (rdata !== 32'h0 || epc_out !== 32'h0) begin
      n_err++; $display("FAIL reset_epc: actual=%h/%h required=0", rdata, epc_out);
    end
    raddr = 5'd9; #1;
    n_vec++;
    if (rdata !== 32'h0 || flush !== 1'b0) begin
      n_err++; $display("FAIL reset_count_flush: actual=%h/%b required=0/0", rdata, flush);
    end
    do_reset();
  endtask

  task automatic test_overflow();
    do_reset();
    instr_valid = 1'b1; exc_vec = 32'h08; pc = 32'hBFC0_1000; is_ds = 1'b0; #1;
    n_vec++;
    if (flush !== 1'b1 || redirect_pc !== VEC) begin
      n_err++; $display("FAIL ov_redirect: actual=%b/%h required=1/%h", flush, redirect_pc, VEC);
    end
    tick();
    idle();
    raddr = 5'd14; #1;
    n_vec++;
    if (rdata !== 32'hBFC0_1000) begin
      n_err++; $display("FAIL ov_epc: actual=%h required=%h", rdata, 32'hBFC0_1000);
    end
    raddr = 5'd13; #1;
    n_vec++;
    if (rdata[6:2] !== 5'h0c) begin
      n_err++; $display("FAIL ov_code: actual=%h required=0c", rdata[6:2]);
    end
    raddr = 5'd12; #1;
    n_vec++;
    if (rdata[1] !== 1'b1 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL ov_exl_idle: actual=%b/%b/%h required=1/0/0", rdata[1], flush, redirect_pc);
    end
  endtask

  task automatic test_priority_ds();
    do_reset();
    instr_valid = 1'b1; exc_vec = 32'h4A; pc = 32'h8000_0010; is_ds = 1'b1;
    bad_addr = 32'h1234_5678;
    tick();
    idle();
    raddr = 5'd13; #1;
    n_vec++;
    if (rdata[6:2] !== 5'h0a || rdata[31] !== 1'b1) begin
      n_err++; $display("FAIL prio_code_bd: actual=%h/%b required=0a/1", rdata[6:2], rdata[31]);
    end
    raddr = 5'd14; #1;
    n_vec++;
    if (rdata !== 32'h8000_000C) begin
      n_err++; $display("FAIL prio_epc: actual=%h required=%h", rdata, 32'h8000_000C);
    end
    raddr = 5'd8; #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++; $display("FAIL prio_badvaddr: actual=%h required=0", rdata);
    end
    // AdES alone loads BadVAddr from bad_addr
    instr_valid = 1'b1; exc_vec = 32'h40; pc = 32'h8000_0020; bad_addr = 32'hCAFE_0003;
    tick();
    idle(); #1;
    n_vec++;
    if (rdata !== 32'hCAFE_0003) begin
      n_err++; $display("FAIL ades_badvaddr: actual=%h required=%h", rdata, 32'hCAFE_0003);
    end
  endtask

  task automatic test_eret();
    do_reset();
    we = 1'b1; waddr = 5'd14; wdata = 32'h8000_0200; #1;
    n_vec++;
    if (epc_out !== 32'h8000_0200) begin
      n_err++; $display("FAIL epc_out_bypass: actual=%h required=%h", epc_out, 32'h8000_0200);
    end
    tick();
    mtc0(5'd12, 32'h0000_0002);
    instr_valid = 1'b1; exc_vec = 32'h80;
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_0000; #1;
    n_vec++;
    if (flush !== 1'b1 || redirect_pc !== 32'h8000_0200) begin
      n_err++; $display("FAIL eret_redirect: actual=%b/%h required=1/%h", flush, redirect_pc, 32'h8000_0200);
    end
    tick();
    idle();
    raddr = 5'd12; #1;
    n_vec++;
    if (rdata[1] !== 1'b0 || epc_out !== 32'h8000_0200) begin
      n_err++; $display("FAIL eret_exl_epc: actual=%b/%h required=0/%h", rdata[1], epc_out, 32'h8000_0200);
    end
    instr_valid = 1'b1; exc_vec = 32'h88; pc = 32'h8000_0300; #1;
    n_vec++;
    if (redirect_pc !== VEC) begin
      n_err++; $display("FAIL eret_ov: actual=%h required=%h", redirect_pc, VEC);
    end
    tick();
    idle();
  endtask

  task automatic test_interrupt();
    do_reset();
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    instr_valid = 1'b1; pc = 32'h8000_1000; #1;
    n_vec++;
    if (flush !== 1'b1 || redirect_pc !== VEC) begin
      n_err++; $display("FAIL int_taken: actual=%b/%h required=1/%h", flush, redirect_pc, VEC);
    end
    tick();
    raddr = 5'd13; #1;
    n_vec++;
    if (rdata[6:2] !== 5'h00 || rdata[10] !== 1'b1) begin
      n_err++; $display("FAIL int_code_ip: actual=%h/%b required=00/1", rdata[6:2], rdata[10]);
    end
    n_vec++;
    if (flush !== 1'b0) begin
      n_err++; $display("FAIL int_masked_exl: actual=%b required=0", flush);
    end
    tick();
    idle();
    hw_int = '0;
  endtask

  task automatic test_timer();
    do_reset();
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd4);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 10; i++) begin
      raddr = (i % 2 == 0) ? 5'd13 : 5'd9; #1;
      n_vec++;
      if (rdata !== m_read(ms, raddr)) begin
        n_err++; $display("FAIL timer_step%0d: actual=%h required=%h", i, rdata, m_read(ms, raddr));
      end
      tick();
    end
    raddr = 5'd13; #1;
    n_vec++;
    if (rdata[30] !== 1'b1) begin
      n_err++; $display("FAIL timer_ti_set: actual=%b required=1", rdata[30]);
    end
    mtc0(5'd11, 32'd100);
    n_vec++;
    if (rdata[30] !== 1'b0) begin
      n_err++; $display("FAIL timer_ti_clear: actual=%b required=0", rdata[30]);
    end
`else
    mtc0(5'd9, 32'h0000_1234);
    mtc0(5'd11, 32'h0000_0004);
    raddr = 5'd9; #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++; $display("FAIL notimer_count: actual=%h required=0", rdata);
    end
    raddr = 5'd11; #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++; $display("FAIL notimer_compare: actual=%h required=0", rdata);
    end
`endif
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 6))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] r;
    logic        e_flush;
    logic [31:0] e_redir, e_rdata, e_epc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      instr_valid = ($urandom_range(0, 3) != 0);
      exc_vec     = {r[31:8], 8'h00};
      if ($urandom_range(0, 2) == 0) exc_vec[7:0] = 8'($urandom) & 8'($urandom);
      pc       = $urandom & 32'hFFFF_FFFC;
      is_ds    = 1'($urandom);
      bad_addr = $urandom;
      hw_int   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      we       = ($urandom_range(0, 2) == 0);
      waddr    = pick_reg();
      wdata    = $urandom;
      raddr    = ($urandom_range(0, 3) == 0) ? waddr : pick_reg();
      #1;
      e_flush = m_exc(ms) || m_eret(ms);
      e_redir = m_exc(ms) ? VEC : (m_eret(ms) ? ms.epc : 32'h0);
      e_rdata = (m_mtc0(ms) && raddr == waddr) ? m_read(m_next(ms), raddr) : m_read(ms, raddr);
      e_epc   = (m_mtc0(ms) && waddr == 5'd14) ? wdata : ms.epc;
      n_vec++;
      if (flush !== e_flush) begin
        n_err++; $display("FAIL rand_flush c%0d: actual=%b required=%b", c, flush, e_flush);
      end
      n_vec++;
      if (redirect_pc !== e_redir) begin
        n_err++; $display("FAIL rand_redirect c%0d: actual=%h required=%h", c, redirect_pc, e_redir);
      end
      n_vec++;
      if (rdata !== e_rdata) begin
        n_err++; $display("FAIL rand_rdata c%0d r%0d: actual=%h required=%h", c, raddr, rdata, e_rdata);
      end
      n_vec++;
      if (epc_out !== e_epc) begin
        n_err++; $display("FAIL rand_epc_out c%0d: actual=%h required=%h", c, epc_out, e_epc);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    resetn = 1'b0; hw_int = '0; raddr = '0;
    idle();
    ms = '0;
    test_reset();
    test_overflow();
    test_priority_ds();
    test_eret();
    test_interrupt();
    test_timer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
